// File: rtl/clk_phase_sched.sv
// clk_phase_sched: programmable clock divider producing a divided clock and a
// phase-shifted copy of it. Period, high time and phase offset are loaded
// through a valid/ready config port. A word accepted while running is parked
// in a shadow set and only becomes active at a period boundary, so neither
// output ever produces a runt pulse.
module clk_phase_sched #(
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 5,
  parameter int DEF_SHIFT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_shift,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             clk_sft_out,
  output logic             period_done
);

  localparam logic [CNT_W-1:0] DEF_PERIOD_W = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_HIGH_W   = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] DEF_SHIFT_W  = CNT_W'(DEF_SHIFT);
  localparam logic [CNT_W-1:0] ONE_W        = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_W        = CNT_W'(2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    RUN_PEND = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Position inside the current period.
  logic [CNT_W-1:0] cnt;

  // Active settings driving the waveform.
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high;
  logic [CNT_W-1:0] shift;

  // Shadow settings waiting for the next period boundary.
  logic [CNT_W-1:0] shd_period;
  logic [CNT_W-1:0] shd_high;
  logic [CNT_W-1:0] shd_shift;

  logic cfg_fire;
  logic cfg_ok;
  logic wrap;
  logic pend_commit;
  logic direct_load;
  logic shadow_load;

  // Phase position of the shifted copy: (cnt + period - shift) mod period.
  // The sum is kept one bit wider; since shift < period it never underflows
  // and stays below 2*period, so a single conditional subtract is enough.
  logic [CNT_W:0] sft_sum;
  logic [CNT_W:0] sft_pos;

  // Handshake, legality check and period-boundary detection.
  always_comb begin
    cfg_fire = cfg_valid & cfg_ready;
    cfg_ok   = (cfg_period >= TWO_W) &&
               (cfg_high >= ONE_W) &&
               (cfg_high < cfg_period) &&
               (cfg_shift < cfg_period);
    wrap     = (cnt == (period - ONE_W));
  end

  // Decide where an accepted word goes and when the shadow set is committed.
  // Dropping en commits a pending word rather than losing it; a word accepted
  // on the same cycle en drops goes straight to the active set.
  always_comb begin
    pend_commit = (state == RUN_PEND) && (!en || wrap);
    direct_load = cfg_fire && cfg_ok && ((state == IDLE) || !en);
    shadow_load = cfg_fire && cfg_ok && (state == RUN) && en;
  end

  // Shifted-phase position with a single conditional wrap.
  always_comb begin
    sft_sum = {1'b0, cnt} + {1'b0, period} - {1'b0, shift};
    if (sft_sum >= {1'b0, period}) begin
      sft_pos = sft_sum - {1'b0, period};
    end else begin
      sft_pos = sft_sum;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     state_next = RUN;
        RUN:      if (shadow_load) state_next = RUN_PEND;
        RUN_PEND: if (wrap) state_next = RUN;
        default:  state_next = IDLE;
      endcase
    end
  end

  // FSM outputs: only a parked shadow word blocks new config.
  always_comb begin
    cfg_ready = (state != RUN_PEND);
  end

  // Period counter; the cycle en is first seen already counts as cnt=0 so
  // clk_out rises one clock after en is raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE_W;
    end
  end

  // Active set: direct load when idle, commit from shadow at a boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= DEF_PERIOD_W;
      high   <= DEF_HIGH_W;
      shift  <= DEF_SHIFT_W;
    end else if (pend_commit) begin
      period <= shd_period;
      high   <= shd_high;
      shift  <= shd_shift;
    end else if (direct_load) begin
      period <= cfg_period;
      high   <= cfg_high;
      shift  <= cfg_shift;
    end
  end

  // Shadow set: captured when a legal word arrives while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_period <= DEF_PERIOD_W;
      shd_high   <= DEF_HIGH_W;
      shd_shift  <= DEF_SHIFT_W;
    end else if (shadow_load) begin
      shd_period <= cfg_period;
      shd_high   <= cfg_high;
      shd_shift  <= cfg_shift;
    end
  end

  // Registered waveform outputs, one cycle behind cnt, forced low when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_out     <= 1'b0;
      clk_sft_out <= 1'b0;
      period_done <= 1'b0;
    end else if (!en) begin
      clk_out     <= 1'b0;
      clk_sft_out <= 1'b0;
      period_done <= 1'b0;
    end else begin
      clk_out     <= (cnt < high);
      clk_sft_out <= (sft_pos < {1'b0, high});
      period_done <= wrap;
    end
  end

  // Rejected-word pulse, one cycle after the offending handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_fire & ~cfg_ok;
    end
  end

endmodule

// File: tb/tb_clk_phase_sched.sv
// Testbench for clk_phase_sched: a cycle model pushes the expected registered
// outputs into a queue before each clock edge; they are popped and compared
// one time unit after the edge. Config legality is table-driven.
module tb_clk_phase_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_period;
  logic [15:0] cfg_high;
  logic [15:0] cfg_shift;
  logic        cfg_err;
  logic        clk_out;
  logic        clk_sft_out;
  logic        period_done;

  clk_phase_sched #(
    .CNT_W(16), .DEF_PERIOD(10), .DEF_HIGH(5), .DEF_SHIFT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_shift(cfg_shift),
    .cfg_err(cfg_err), .clk_out(clk_out), .clk_sft_out(clk_sft_out),
    .period_done(period_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic ready;
    logic err;
    logic co;
    logic so;
    logic pd;
  } obs_t;

  obs_t exp_q[$];

  typedef struct {
    int   per;
    int   hi;
    int   sh;
    logic err;
  } cfg_vec_t;

  // Reference model state: 0 idle, 1 run, 2 run with pending word.
  int m_state, m_cnt, m_per, m_high, m_shift, s_per, s_high, s_shift;

  task automatic model_reset();
    m_state = 0; m_cnt = 0;
    m_per = 10; m_high = 5; m_shift = 0;
    s_per = 10; s_high = 5; s_shift = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    obs_t nx;
    bit acc, ok, wrp;
    int cp, ch, cs;
    cp = int'(cfg_period); ch = int'(cfg_high); cs = int'(cfg_shift);
    acc = cfg_valid && (m_state != 2);
    ok  = (cp >= 2) && (ch >= 1) && (ch <= cp - 1) && (cs < cp);
    nx.err = acc && !ok;
    if (en) begin
      nx.co = (m_cnt < m_high);
      nx.so = (((m_cnt - m_shift + m_per) % m_per) < m_high);
      nx.pd = (m_cnt == m_per - 1);
    end else begin
      nx.co = 1'b0; nx.so = 1'b0; nx.pd = 1'b0;
    end
    wrp = en && (m_cnt == m_per - 1);
    if (!en) begin
      if (m_state == 2) begin
        m_per = s_per; m_high = s_high; m_shift = s_shift;
      end else if (acc && ok) begin
        m_per = cp; m_high = ch; m_shift = cs;
      end
      m_state = 0;
      m_cnt = 0;
    end else begin
      case (m_state)
        0: begin
          if (acc && ok) begin m_per = cp; m_high = ch; m_shift = cs; end
          m_state = 1;
        end
        1: if (acc && ok) begin s_per = cp; s_high = ch; s_shift = cs; m_state = 2; end
        default: if (wrp) begin m_per = s_per; m_high = s_high; m_shift = s_shift; m_state = 1; end
      endcase
      m_cnt = wrp ? 0 : m_cnt + 1;
    end
    nx.ready = (m_state != 2);
    exp_q.push_back(nx);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // One clock: predict, clock, compare the scoreboard head against the DUT.
  task automatic step();
    obs_t e, a;
    model_step();
    @(posedge clk);
    #1;
    a = '{ready: cfg_ready, err: cfg_err, co: clk_out, so: clk_sft_out, pd: period_done};
    e = exp_q.pop_front();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL cycle t=%0t: got rdy/err/co/so/pd=%b expected %b", $time, a, e);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic offer(input int p, input int h, input int s);
    cfg_period = 16'(p); cfg_high = 16'(h); cfg_shift = 16'(s);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_clk_out"}, int'(clk_out), 0);
    chk({tag, "_clk_sft"}, int'(clk_sft_out), 0);
    chk({tag, "_pd"}, int'(period_done), 0);
    chk({tag, "_err"}, int'(cfg_err), 0);
    chk({tag, "_ready"}, int'(cfg_ready), 1);
  endtask

  cfg_vec_t idle_vecs[7];
  cfg_vec_t bad_vecs[3];

  initial begin
    int pd_cnt, hi_cnt, first_co, first_so, found;

    idle_vecs[0] = '{per: 4, hi: 1, sh: 0, err: 1'b0};
    idle_vecs[1] = '{per: 8, hi: 0, sh: 0, err: 1'b1};
    idle_vecs[2] = '{per: 1, hi: 1, sh: 0, err: 1'b1};
    idle_vecs[3] = '{per: 8, hi: 2, sh: 8, err: 1'b1};
    idle_vecs[4] = '{per: 8, hi: 8, sh: 0, err: 1'b1};
    idle_vecs[5] = '{per: 2, hi: 1, sh: 1, err: 1'b0};
    idle_vecs[6] = '{per: 8, hi: 2, sh: 3, err: 1'b0};
    bad_vecs[0]  = '{per: 4, hi: 0, sh: 0, err: 1'b1};
    bad_vecs[1]  = '{per: 1, hi: 1, sh: 0, err: 1'b1};
    bad_vecs[2]  = '{per: 4, hi: 1, sh: 4, err: 1'b1};

    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    cfg_period = '0; cfg_high = '0; cfg_shift = '0;
    model_reset();
    #12;
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    // Defaults: 5 high / 5 low, shifted copy identical, done every 10.
    en = 1'b1;
    step();
    chk("first_high_after_en", int'(clk_out), 1);
    pd_cnt = 0;
    for (int i = 1; i < 30; i++) begin
      step();
      if (period_done) pd_cnt++;
      if (clk_sft_out !== clk_out) chk("sft_equals_out", int'(clk_sft_out), int'(clk_out));
    end
    chk("pd_count_30", pd_cnt, 3);
    en = 1'b0;
    step();
    chk("en_low_clk_out", int'(clk_out), 0);

    // Config legality table, applied while idle.
    foreach (idle_vecs[i]) begin
      offer(idle_vecs[i].per, idle_vecs[i].hi, idle_vecs[i].sh);
      chk($sformatf("idle_cfg%0d_err", i), int'(cfg_err), int'(idle_vecs[i].err));
      chk($sformatf("idle_cfg%0d_ready", i), int'(cfg_ready), 1);
    end

    // period=8 high=2 shift=3: shifted copy rises 3 cycles after clk_out.
    en = 1'b1;
    first_co = -1; first_so = -1; hi_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (clk_out) hi_cnt++;
      if (clk_out && first_co < 0) first_co = i;
      if (clk_sft_out && first_so < 0) first_so = i;
    end
    chk("p8_high_count", hi_cnt, 4);
    chk("p8_first_co", first_co, 0);
    chk("p8_shift_delay", first_so - first_co, 3);

    // Mid-period reconfigure to period=4: ready drops until the wrap.
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (m_cnt == 3) found = 1; else step();
    end
    chk("reach_mid_period", found, 1);
    offer(4, 1, 0);
    chk("pend_ready_low", int'(cfg_ready), 0);
    run(20);
    chk("pend_ready_back", int'(cfg_ready), 1);

    // Illegal words while running: each pulses err, ready stays high.
    foreach (bad_vecs[i]) begin
      offer(bad_vecs[i].per, bad_vecs[i].hi, bad_vecs[i].sh);
      chk($sformatf("run_bad%0d_err", i), int'(cfg_err), int'(bad_vecs[i].err));
      chk($sformatf("run_bad%0d_ready", i), int'(cfg_ready), 1);
      step();
      chk($sformatf("run_bad%0d_err_clear", i), int'(cfg_err), 0);
    end
    run(8);

    // Word offered on the period_done cycle waits one full old period.
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (period_done) found = 1;
    end
    chk("pd_seen", found, 1);
    offer(6, 3, 2);
    run(18);

    // Word accepted on the wrap cycle itself applies at the following wrap.
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (m_cnt == m_per - 1) found = 1; else step();
    end
    chk("reach_wrap", found, 1);
    offer(5, 2, 4);
    run(20);

    // en drop with a pending word: outputs off next cycle, word kept.
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (m_cnt == 1) found = 1; else step();
    end
    chk("reach_cnt1", found, 1);
    offer(3, 1, 2);
    step();
    en = 1'b0;
    step();
    chk("en_drop_clk_out", int'(clk_out), 0);
    chk("en_drop_ready", int'(cfg_ready), 1);
    run(3);
    en = 1'b1;
    pd_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (period_done) pd_cnt++;
    end
    chk("restart_p3_pd_count", pd_cnt, 4);

    // Asynchronous reset mid-run, then restart on defaults.
    run(4);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pd_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (period_done) pd_cnt++;
    end
    chk("post_rst_pd_count", pd_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
